// File: rtl/riscvbyp_imem_fetch_queue_if.sv
// Handshake bundle between imem request/response, redirect and Decode for the fetch queue.
// slave is the queue side; master is the surrounding fetch/decode logic.
interface riscvbyp_imem_fetch_queue_if #(
  parameter int DATA_W = 32
);
  logic              req_fire;
  logic              req_allow;
  logic              resp_val;
  logic [DATA_W-1:0] resp_data;
  logic              squash;
  logic              deq_val;
  logic              deq_rdy;
  logic [DATA_W-1:0] deq_msg_data;

  modport master (
    output req_fire, resp_val, resp_data, squash, deq_rdy,
    input  req_allow, deq_val, deq_msg_data
  );

  modport slave (
    input  req_fire, resp_val, resp_data, squash, deq_rdy,
    output req_allow, deq_val, deq_msg_data
  );
endinterface

// File: rtl/riscvbyp_imem_fetch_queue.sv
// Two-entry imem response queue with credit-gated requests, empty-queue bypass to Decode,
// and redirect flush that discards responses still in flight.
module riscvbyp_imem_fetch_queue #(
  parameter int DATA_W = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  riscvbyp_imem_fetch_queue_if.slave    q
);

  logic [DATA_W-1:0] mem [2];
  logic              head;
  logic              tail;
  logic [1:0]        count;
  logic [1:0]        outstanding;
  logic [1:0]        drop_cnt;

  logic drop_active;
  logic resp_keep;
  logic q_nonempty;
  logic deq_fire;
  logic deq_pop;
  logic enq;

  assign drop_active = (drop_cnt != 2'd0);
  assign resp_keep   = q.resp_val && !drop_active && !q.squash;
  assign q_nonempty  = (count != 2'd0);

  assign q.deq_val      = !q.squash && (q_nonempty || resp_keep);
  assign q.deq_msg_data = q_nonempty ? mem[head] : q.resp_data;

  assign deq_fire = q.deq_val && q.deq_rdy;
  assign deq_pop  = deq_fire && q_nonempty;
  // A kept response is stored unless it leaves straight through the bypass.
  assign enq      = resp_keep && !(deq_fire && !q_nonempty);

  // Credits come from registers only, so every issued request owns a free slot.
  assign q.req_allow = ({1'b0, outstanding} + {1'b0, count}) < 3'd2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head        <= 1'b0;
      tail        <= 1'b0;
      count       <= 2'd0;
      outstanding <= 2'd0;
      drop_cnt    <= 2'd0;
    end else begin
      outstanding <= outstanding + {1'b0, q.req_fire} - {1'b0, q.resp_val};
      if (q.squash) begin
        // Older in-flight responses are dropped; a request fired now is the redirect target.
        head     <= 1'b0;
        tail     <= 1'b0;
        count    <= 2'd0;
        drop_cnt <= outstanding - {1'b0, q.resp_val};
      end else begin
        if (q.resp_val && drop_active)
          drop_cnt <= drop_cnt - 2'd1;
        count <= count + {1'b0, enq} - {1'b0, deq_pop};
        if (deq_pop)
          head <= ~head;
        if (enq)
          tail <= ~tail;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq)
      mem[tail] <= q.resp_data;
  end

endmodule
